dmem_pipe: RTL and testbench

Parametrised successor to the core's single-cycle data memory: a word-organised RAM with a valid/ready request port, configurable access latency, RV32 byte/half/word load-store formatting selected by funct3, and fault reporting. It sits between the load/store path of the next-generation (stall-capable) core and on-chip storage. The core stalls on `req_ready`/`rsp_valid` instead of assuming a combinational read.

---
 rtl/dmem_pipe.sv | 237 +++++++++++++++++++++++
 tb/tb_dmem_pipe.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_pipe.sv
// dmem_pipe: word-organised data RAM with a valid/ready request port, fixed access latency
// and RV32 load/store formatting. Define DMEM_PIPE_FAULT_EN to compile in fault checking.
module dmem_pipe #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_next_s;
  logic [CW-1:0]  cnt_r;
  logic [CW-1:0]  cnt_next_s;
  logic           accept_s;
  logic           exec_s;

  logic           we_r;
  logic [31:0]    addr_r;
  logic [31:0]    wdata_r;
  logic [2:0]     funct3_r;

  logic           op_we_s;
  logic [31:0]    op_addr_s;
  logic [31:0]    op_wdata_s;
  logic [2:0]     op_funct3_s;

  logic [AW-1:0]  idx_s;
  logic [31:0]    rd_word_s;
  logic [3:0]     wr_be_s;
  logic [31:0]    wr_data_s;
  logic           wr_en_s;
  logic           fault_s;

  logic [31:0]    mem_r [DEPTH_WORDS];

  // Selects the lane(s) touched by a store; illegal store encodings touch nothing.
  function automatic logic [3:0] store_be(input logic [1:0] lane, input logic [2:0] f3);
    logic [3:0] be;
    case (f3)
      3'b000:  be = 4'b0001 << lane;
      3'b001:  be = lane[1] ? 4'b1100 : 4'b0011;
      3'b010:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_data(input logic [31:0] wd, input logic [2:0] f3);
    logic [31:0] d;
    case (f3)
      3'b000:  d = {4{wd[7:0]}};
      3'b001:  d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_fmt(input logic [31:0] word, input logic [1:0] lane,
                                           input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = word;
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  assign req_ready = (state_r == ST_IDLE);
  assign busy      = (state_r == ST_WAIT) || (state_r == ST_RESP);

  // With LATENCY=1 the access executes on the accept edge, so operands bypass the latch in IDLE.
  assign op_we_s     = (state_r == ST_IDLE) ? req_we     : we_r;
  assign op_addr_s   = (state_r == ST_IDLE) ? req_addr   : addr_r;
  assign op_wdata_s  = (state_r == ST_IDLE) ? req_wdata  : wdata_r;
  assign op_funct3_s = (state_r == ST_IDLE) ? req_funct3 : funct3_r;

  assign idx_s     = op_addr_s[AW+1:2];
  assign rd_word_s = mem_r[idx_s];
  assign wr_be_s   = store_be(op_addr_s[1:0], op_funct3_s);
  assign wr_data_s = store_data(op_wdata_s, op_funct3_s);
  assign wr_en_s   = exec_s && op_we_s && !fault_s && !reset;

`ifdef DMEM_PIPE_FAULT_EN
  logic misalign_s;
  logic illegal_s;
  logic range_s;

  // Classifies the access as misaligned, illegally encoded or out of range.
  always_comb begin
    misalign_s = 1'b0;
    illegal_s  = 1'b0;
    range_s    = (op_addr_s[31:AW+2] != '0);
    case (op_funct3_s)
      3'b000: illegal_s = 1'b0;
      3'b001: misalign_s = op_addr_s[0];
      3'b010: misalign_s = (op_addr_s[1:0] != 2'b00);
      3'b100: illegal_s = op_we_s;
      3'b101: begin
        misalign_s = op_addr_s[0];
        illegal_s  = op_we_s;
      end
      default: illegal_s = 1'b1;
    endcase
  end

  assign fault_s = misalign_s || illegal_s || range_s;
`else
  logic unused_addr_s;
  assign unused_addr_s = ^op_addr_s[31:AW+2];
  assign fault_s       = 1'b0;
`endif

  // Next-state and counter logic for the IDLE/WAIT/RESP sequence.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    accept_s     = 1'b0;
    exec_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          accept_s = 1'b1;
          if (LATENCY == 1) begin
            state_next_s = ST_RESP;
            exec_s       = 1'b1;
          end else begin
            state_next_s = ST_WAIT;
            cnt_next_s   = CNT_LOAD;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_next_s = cnt_r - CW'(1);
        if (cnt_r == CW'(1)) begin
          state_next_s = ST_RESP;
          exec_s       = 1'b1;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
        cnt_next_s   = '0;
      end
    endcase
  end

  // State and latency counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Request capture on handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_r     <= 1'b0;
      addr_r   <= 32'd0;
      wdata_r  <= 32'd0;
      funct3_r <= 3'd0;
    end else if (accept_s) begin
      we_r     <= req_we;
      addr_r   <= req_addr;
      wdata_r  <= req_wdata;
      funct3_r <= req_funct3;
    end
  end

  // Response registers: loaded on the execute edge, cleared one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_fault <= 1'b0;
    end else if (exec_s) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= (op_we_s || fault_s) ? 32'd0
                                        : load_fmt(rd_word_s, op_addr_s[1:0], op_funct3_s);
      rsp_fault <= fault_s;
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_fault <= 1'b0;
    end
  end

  // Storage array with byte-lane writes; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be_s[i]) begin
          mem_r[idx_s][8*i +: 8] <= wr_data_s[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_pipe.sv
// Randomised self-checking bench for dmem_pipe against a byte-addressed reference model;
// a second instance with LATENCY=3 checks back-to-back throughput.
module tb_dmem_pipe;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  logic        clk;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid, rsp_fault, busy;
  logic [31:0] rsp_rdata;

  logic        t_req_valid, t_req_ready, t_req_we;
  logic [31:0] t_req_addr, t_req_wdata;
  logic [2:0]  t_req_funct3;
  logic        t_rsp_valid, t_rsp_fault, t_busy;
  logic [31:0] t_rsp_rdata;

  int          n_tests;
  int          n_fail;
  logic [31:0] last_rdata;
  logic        last_fault;
  logic [7:0]  mem_b [DEPTH*4];

  dmem_pipe #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault), .busy(busy)
  );

  dmem_pipe #(.DEPTH_WORDS(DEPTH), .LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .req_valid(t_req_valid), .req_ready(t_req_ready),
    .req_we(t_req_we), .req_addr(t_req_addr), .req_wdata(t_req_wdata),
    .req_funct3(t_req_funct3), .rsp_valid(t_rsp_valid), .rsp_rdata(t_rsp_rdata),
    .rsp_fault(t_rsp_fault), .busy(t_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: access as a little-endian run of bytes; result and fault from the RV32 rules.
  function automatic void model_access(input bit we, input logic [31:0] addr,
                                       input logic [31:0] wd, input logic [2:0] f3,
                                       output bit efault, output logic [31:0] erd);
    int size;
    bit sgn;
    bit legal;
    longint unsigned widx;
    int base;
    logic [31:0] v;
    size = 4; sgn = 1'b0; legal = 1'b1;
    case (f3)
      3'd0: begin size = 1; sgn = 1'b1; end
      3'd1: begin size = 2; sgn = 1'b1; end
      3'd2: size = 4;
      3'd4: begin size = 1; legal = !we; end
      3'd5: begin size = 2; legal = !we; end
      default: legal = 1'b0;
    endcase
    widx = addr / 4;
    efault = 1'b0;
`ifdef DMEM_PIPE_FAULT_EN
    efault = !legal || ((addr % size) != 0) || (widx >= DEPTH);
`endif
    widx = widx % DEPTH;
    base = int'(widx) * 4 + (int'(addr % 4) / size) * size;
    erd = 32'd0;
    if (!efault && legal) begin
      if (we) begin
        for (int i = 0; i < size; i++) mem_b[base+i] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < size; i++) v = v | (32'(mem_b[base+i]) << (8*i));
        if (sgn && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
        erd = v;
      end
    end
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after the response.
  task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [2:0] f3, input string tag);
    bit ef;
    logic [31:0] er;
    int cyc;
    model_access(we, addr, wd, f3, ef, er);
    check_val({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_funct3 = f3;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom;
    req_wdata = $urandom; req_funct3 = 3'($urandom);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!rsp_valid && cyc < 20);
    check_val({tag, "_lat"}, 32'(cyc), 32'(LAT));
    check_val({tag, "_fault"}, 32'(rsp_fault), 32'(ef));
    check_val({tag, "_rdata"}, rsp_rdata, er);
    last_rdata = rsp_rdata;
    last_fault = rsp_fault;
    @(negedge clk);
    check_val({tag, "_after"}, {28'd0, rsp_valid, rsp_fault, req_ready, busy}, 32'h2);
    check_val({tag, "_after_d"}, rsp_rdata, 32'd0);
  endtask

  initial begin
    logic [31:0] prior;
    int n_rsp;
    n_tests = 0; n_fail = 0;
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_funct3 = 3'd0;
    t_req_valid = 1'b0; t_req_we = 1'b0; t_req_addr = 32'd0; t_req_wdata = 32'd0;
    t_req_funct3 = 3'd0;
    #12;
    check_val("rst_out", {28'd0, rsp_valid, rsp_fault, req_ready, busy}, 32'h2);
    check_val("rst_rdata", rsp_rdata, 32'd0);
    check_val("rst_out3", {28'd0, t_rsp_valid, t_rsp_fault, t_req_ready, t_busy}, 32'h2);
    @(negedge clk);
    reset = 1'b0;

    // Back-to-back stores with req_valid held: one accept and one response every 4 cycles.
    t_req_valid = 1'b1; t_req_we = 1'b1; t_req_funct3 = 3'd2;
    n_rsp = 0;
    for (int c = 0; c < 24; c++) begin
      t_req_addr = 32'(c * 4);
      t_req_wdata = $urandom;
      check_val("tp_ready", 32'(t_req_ready), 32'(c % 4 == 0));
      check_val("tp_busy", 32'(t_busy), 32'(c % 4 != 0));
      check_val("tp_rsp", 32'(t_rsp_valid), 32'(c % 4 == 3));
      if (t_rsp_valid) n_rsp++;
      @(negedge clk);
    end
    t_req_valid = 1'b0;
    check_val("tp_count", 32'(n_rsp), 32'd6);

    for (int w = 0; w < DEPTH; w++) do_req(1'b1, 32'(w * 4), $urandom, 3'd2, "init");

    do_req(1'b1, 32'h10, 32'hDEADBEEF, 3'd2, "sw");
    do_req(1'b0, 32'h10, 32'd0, 3'd2, "lw");
    check_val("lw_deadbeef", last_rdata, 32'hDEADBEEF);
    do_req(1'b1, 32'h13, 32'h123456A5, 3'd0, "sb");
    do_req(1'b0, 32'h13, 32'd0, 3'd0, "lb");
    check_val("lb_val", last_rdata, 32'hFFFFFFA5);
    do_req(1'b0, 32'h13, 32'd0, 3'd4, "lbu");
    check_val("lbu_val", last_rdata, 32'h000000A5);
    do_req(1'b0, 32'h10, 32'd0, 3'd2, "lw_sb");
    check_val("lw_sb_val", last_rdata, 32'hA5ADBEEF);
    do_req(1'b1, 32'h12, 32'h77778001, 3'd1, "sh");
    do_req(1'b0, 32'h12, 32'd0, 3'd1, "lh");
    check_val("lh_val", last_rdata, 32'hFFFF8001);
    do_req(1'b0, 32'h12, 32'd0, 3'd5, "lhu");
    check_val("lhu_val", last_rdata, 32'h00008001);
    do_req(1'b0, 32'h10, 32'd0, 3'd2, "lw_sh");
    check_val("lw_sh_val", last_rdata, 32'h8001BEEF);

    do_req(1'b1, 32'h11, 32'h12345678, 3'd2, "sw_mis");
`ifdef DMEM_PIPE_FAULT_EN
    check_val("sw_mis_f", 32'(last_fault), 32'd1);
    check_val("sw_mis_d", last_rdata, 32'd0);
`endif
    do_req(1'b0, 32'h10, 32'd0, 3'd2, "lw_keep");
`ifdef DMEM_PIPE_FAULT_EN
    check_val("lw_keep_v", last_rdata, 32'h8001BEEF);
`endif
    do_req(1'b0, 32'(DEPTH * 4), 32'd0, 3'd2, "lw_oor");
`ifdef DMEM_PIPE_FAULT_EN
    check_val("lw_oor_f", 32'(last_fault), 32'd1);
`endif
    do_req(1'b0, 32'h10, 32'd0, 3'b011, "ill");
`ifdef DMEM_PIPE_FAULT_EN
    check_val("ill_f", 32'(last_fault), 32'd1);
`endif

    // Reset one cycle after accepting a store: nothing written, no response.
    prior = {mem_b[35], mem_b[34], mem_b[33], mem_b[32]};
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
    req_funct3 = 3'd2;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_val("midrst_out", {28'd0, rsp_valid, rsp_fault, req_ready, busy}, 32'h2);
    check_val("midrst_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_val("midrst_norsp", {30'd0, rsp_valid, busy}, 32'd0);
      @(negedge clk);
    end
    do_req(1'b0, 32'h20, 32'd0, 3'd2, "rst_lw");
    check_val("rst_prior", last_rdata, prior);

    for (int k = 0; k < 300; k++) begin
      bit we;
      logic [31:0] a;
      logic [2:0] f;
      we = 1'($urandom);
      f = 3'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 2))
          0: f = we ? 3'd0 : 3'(4 * $urandom_range(0, 1));
          1: f = we ? 3'd1 : 3'(1 + 4 * $urandom_range(0, 1));
          default: f = 3'd2;
        endcase
      end
      if ($urandom_range(0, 3) == 0) a = $urandom;
      else a = 32'($urandom_range(0, DEPTH * 4 + 7));
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      do_req(we, a, $urandom, f, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
